// File: rtl/fft_pp_pkg.sv
// fft_pp_pkg: shared types and helpers for the FFT output ping-pong controller.
//   ADDR_W_DEF   default bank address width (256-entry banks)
//   bank_state_t per-bank life cycle EMPTY -> FILLING -> FULL -> DRAINING
//   bitrev()     reverses the low w bits of an address
package fft_pp_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int MAX_W      = 16;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  // Reverses bits [w-1:0] of x; bits at and above w come back as zero.
  function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] x, input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) r[i] = x[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pp_bank_fsm.sv
// fft_pp_bank_fsm: life-cycle state of one ping-pong bank.
//   clock_c, reset   clock and asynchronous active-high reset
//   wr_first         first write of a frame lands in this bank
//   wr_last          final write of a frame lands in this bank
//   rd_first         first read of a frame is taken from this bank
//   rd_last          final read of a frame is taken from this bank
//   state            current bank state
module fft_pp_bank_fsm
  import fft_pp_pkg::*;
(
  input  logic        clock_c,
  input  logic        reset,
  input  logic        wr_first,
  input  logic        wr_last,
  input  logic        rd_first,
  input  logic        rd_last,
  output bank_state_t state
);

  bank_state_t state_q, state_d;

  always_ff @(posedge clock_c or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // The last-event checks come first so a degenerate one-entry bank still
  // completes its frame in a single access.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (wr_last)       state_d = FULL;
        else if (wr_first) state_d = FILLING;
      end
      FILLING: begin
        if (wr_last) state_d = FULL;
      end
      FULL: begin
        if (rd_last)       state_d = EMPTY;
        else if (rd_first) state_d = DRAINING;
      end
      DRAINING: begin
        if (rd_last) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/fft_pingpong_ctrl.sv
// fft_pingpong_ctrl: address/strobe sequencer for the FFT output reorder
// buffer. Samples are written into the filling bank at bit-reversed
// addresses while the other bank drains in natural order.
//   clock_c, reset, enable         clock, async active-high reset, clock enable
//   wr_valid / wr_ready / wr_en    upstream handshake and bank write strobe
//   wr_bank, wr_addr               bank being filled, bit-reversed address
//   rd_ready / rd_en               downstream accept and bank read strobe
//   rd_bank, rd_addr               bank being drained, natural-order address
//   out_valid, out_sel, frame_last read-side flags delayed by RD_LAT
//   overflow                       sticky: sample offered while not ready
module fft_pingpong_ctrl
  import fft_pp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clock_c,
  input  logic              reset,
  input  logic              enable,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_ready,
  output logic              rd_en,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              out_valid,
  output logic              out_sel,
  output logic              frame_last,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic              ovf_q, ovf_d;
  logic [RD_LAT-1:0] vld_q, sel_q, last_q;
  bank_state_t       bank_st [2];

  logic wr_open, rd_open;

  assign wr_open = (bank_st[wr_bank_q] == EMPTY) || (bank_st[wr_bank_q] == FILLING);
  assign rd_open = (bank_st[rd_bank_q] == FULL)  || (bank_st[rd_bank_q] == DRAINING);

  // Strobes are masked while reset is held so nothing reaches the RAMs
  // during the asynchronous clear.
  assign wr_ready = enable & ~reset & wr_open;
  assign wr_en    = wr_valid & wr_ready;
  assign rd_en    = enable & ~reset & rd_ready & rd_open;

  assign wr_bank  = wr_bank_q;
  assign wr_addr  = ADDR_W'(bitrev(MAX_W'(wr_cnt_q), ADDR_W));
  assign rd_bank  = rd_bank_q;
  assign rd_addr  = rd_cnt_q;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic wr_hit, rd_hit;
    assign wr_hit = wr_en & (wr_bank_q == 1'(b));
    assign rd_hit = rd_en & (rd_bank_q == 1'(b));

    fft_pp_bank_fsm u_bank (
      .clock_c  (clock_c),
      .reset    (reset),
      .wr_first (wr_hit & (wr_cnt_q == '0)),
      .wr_last  (wr_hit & (wr_cnt_q == CNT_MAX)),
      .rd_first (rd_hit & (rd_cnt_q == '0)),
      .rd_last  (rd_hit & (rd_cnt_q == CNT_MAX)),
      .state    (bank_st[b])
    );
  end

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    ovf_d     = ovf_q | (wr_valid & enable & ~wr_ready);
    if (wr_en) begin
      wr_cnt_d = wr_cnt_q + ADDR_W'(1);
      if (wr_cnt_q == CNT_MAX) wr_bank_d = ~wr_bank_q;
    end
    if (rd_en) begin
      rd_cnt_d = rd_cnt_q + ADDR_W'(1);
      if (rd_cnt_q == CNT_MAX) rd_bank_d = ~rd_bank_q;
    end
  end

  always_ff @(posedge clock_c or posedge reset) begin
    if (reset) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (enable) begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      ovf_q     <= ovf_d;
    end
  end

  // Read-side flags ride a RD_LAT-deep shift register matching the RAM
  // read latency; it freezes with enable so flags stay aligned with data.
  always_ff @(posedge clock_c or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      sel_q  <= '0;
      last_q <= '0;
    end else if (enable) begin
      vld_q[0]  <= rd_en;
      sel_q[0]  <= rd_bank_q;
      last_q[0] <= rd_en & (rd_cnt_q == CNT_MAX);
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        sel_q[i]  <= sel_q[i-1];
        last_q[i] <= last_q[i-1];
      end
    end
  end

  assign out_valid  = vld_q[RD_LAT-1];
  assign out_sel    = sel_q[RD_LAT-1];
  assign frame_last = last_q[RD_LAT-1];
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_fft_pingpong_ctrl.sv
// Testbench for fft_pingpong_ctrl: frame-level occupancy model, per-cycle
// compare on the falling edge, plus directed scenarios with literal checks.
module tb_fft_pingpong_ctrl;

  localparam int AW  = 8;
  localparam int N   = 256;
  localparam int LAT = 1;

  logic          clock_c = 1'b0;
  logic          reset, enable, wr_valid, rd_ready;
  logic          wr_ready, wr_en, wr_bank, rd_en, rd_bank;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          out_valid, out_sel, frame_last, overflow;

  always #5 clock_c = ~clock_c;

  fft_pingpong_ctrl #(.ADDR_W(AW), .RD_LAT(LAT)) dut (
    .clock_c    (clock_c),
    .reset      (reset),
    .enable     (enable),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_en      (wr_en),
    .wr_bank    (wr_bank),
    .wr_addr    (wr_addr),
    .rd_ready   (rd_ready),
    .rd_en      (rd_en),
    .rd_bank    (rd_bank),
    .rd_addr    (rd_addr),
    .out_valid  (out_valid),
    .out_sel    (out_sel),
    .frame_last (frame_last),
    .overflow   (overflow)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int brev(input int x);
    int r = 0;
    int v = x;
    for (int i = 0; i < AW; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  // Model: per-bank count of samples written and read in the current frame.
  int m_wc [2];
  int m_rc [2];
  int m_wb, m_rb;
  int m_ovf;
  int p_vld [LAT];
  int p_sel [LAT];
  int p_last[LAT];

  int wlog[$];
  int ov_seen, fl_seen, fl_at, both_cnt;

  int e_wrdy, e_wen, e_ren, e_waddr, e_raddr;

  always @(negedge clock_c) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin m_wc[b] = 0; m_rc[b] = 0; end
      m_wb = 0; m_rb = 0; m_ovf = 0;
      for (int i = 0; i < LAT; i++) begin p_vld[i] = 0; p_sel[i] = 0; p_last[i] = 0; end
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_rd_en", int'(rd_en), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_wr_addr", int'(wr_addr), 0);
      chk("rst_rd_addr", int'(rd_addr), 0);
    end else begin
      e_wrdy  = (enable && m_wc[m_wb] < N) ? 1 : 0;
      e_wen   = (e_wrdy && wr_valid) ? 1 : 0;
      e_ren   = (enable && rd_ready && m_wc[m_rb] == N) ? 1 : 0;
      e_waddr = brev(m_wc[m_wb] == N ? 0 : m_wc[m_wb]);
      e_raddr = m_rc[m_rb];

      chk("wr_ready", int'(wr_ready), e_wrdy);
      chk("wr_en", int'(wr_en), e_wen);
      chk("wr_bank", int'(wr_bank), m_wb);
      chk("wr_addr", int'(wr_addr), e_waddr);
      chk("rd_en", int'(rd_en), e_ren);
      chk("rd_bank", int'(rd_bank), m_rb);
      chk("rd_addr", int'(rd_addr), e_raddr);
      chk("out_valid", int'(out_valid), p_vld[LAT-1]);
      if (p_vld[LAT-1] != 0) chk("out_sel", int'(out_sel), p_sel[LAT-1]);
      chk("frame_last", int'(frame_last), p_last[LAT-1]);
      chk("overflow", int'(overflow), m_ovf);
      if (wr_en && rd_en) chk("bank_conflict", int'(wr_bank != rd_bank), 1);

      if (wr_en) wlog.push_back(int'(wr_addr));
      if (out_valid) ov_seen++;
      if (frame_last) begin fl_seen++; fl_at = ov_seen; end
      if (wr_en && rd_en) both_cnt++;

      if (enable) begin
        for (int i = LAT - 1; i > 0; i--) begin
          p_vld[i] = p_vld[i-1]; p_sel[i] = p_sel[i-1]; p_last[i] = p_last[i-1];
        end
        p_vld[0]  = e_ren;
        p_sel[0]  = m_rb;
        p_last[0] = (e_ren && m_rc[m_rb] == N - 1) ? 1 : 0;
        if (wr_valid && !e_wrdy) m_ovf = 1;
        if (e_wen) begin
          m_wc[m_wb]++;
          if (m_wc[m_wb] == N) m_wb = 1 - m_wb;
        end
        if (e_ren) begin
          m_rc[m_rb]++;
          if (m_rc[m_rb] == N) begin
            m_rc[m_rb] = 0;
            m_wc[m_rb] = 0;
            m_rb = 1 - m_rb;
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock_c);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; enable = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  int wa, ra;

  initial begin
    reset = 1'b1; enable = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0;
    cyc(2);
    chk("init_wr_bank", int'(wr_bank), 0);
    chk("init_rd_bank", int'(rd_bank), 0);
    chk("init_overflow", int'(overflow), 0);
    reset = 1'b0;

    // Single frame
    wlog.delete();
    wr_valid = 1'b1;
    cyc(N);
    wr_valid = 1'b0;
    chk("sf_wlog_size", wlog.size(), N);
    chk("sf_addr0", wlog[0], 0);
    chk("sf_addr1", wlog[1], 128);
    chk("sf_addr2", wlog[2], 64);
    chk("sf_addr3", wlog[3], 192);
    chk("sf_addr255", wlog[N-1], 255);
    chk("sf_wr_bank", int'(wr_bank), 1);
    chk("sf_wr_ready", int'(wr_ready), 1);
    chk("sf_rd_en_idle", int'(rd_en), 0);

    // Drain
    ov_seen = 0; fl_seen = 0; fl_at = 0;
    rd_ready = 1'b1;
    #1;
    chk("dr_first_rd_en", int'(rd_en), 1);
    chk("dr_first_rd_addr", int'(rd_addr), 0);
    chk("dr_first_rd_bank", int'(rd_bank), 0);
    cyc(N + 4);
    rd_ready = 1'b0;
    chk("dr_out_valid_cnt", ov_seen, N);
    chk("dr_frame_last_cnt", fl_seen, 1);
    chk("dr_frame_last_pos", fl_at, N);
    chk("dr_rd_bank", int'(rd_bank), 1);

    // Streaming over four frames
    do_reset();
    wr_valid = 1'b1; rd_ready = 1'b1;
    cyc(N + 4);
    both_cnt = 0;
    cyc(3 * N);
    chk("st_both_every_cycle", both_cnt, 3 * N);
    chk("st_overflow", int'(overflow), 0);
    wr_valid = 1'b0; rd_ready = 1'b0;

    // Backpressure overflow
    do_reset();
    wr_valid = 1'b1;
    cyc(2 * N);
    chk("bp_wr_ready", int'(wr_ready), 0);
    chk("bp_overflow_before", int'(overflow), 0);
    chk("bp_wr_bank", int'(wr_bank), 0);
    cyc(1);
    wr_valid = 1'b0;
    chk("bp_overflow_after", int'(overflow), 1);
    chk("bp_wr_addr_hold", int'(wr_addr), 0);
    chk("bp_wr_bank_hold", int'(wr_bank), 0);
    rd_ready = 1'b1;
    #1;
    chk("bp_bank0_full", int'(rd_en), 1);
    rd_ready = 1'b0;

    // Simultaneous swap
    do_reset();
    wr_valid = 1'b1;
    cyc(N);
    rd_ready = 1'b1;
    cyc(N);
    chk("sw_wr_bank", int'(wr_bank), 0);
    chk("sw_rd_bank", int'(rd_bank), 1);
    chk("sw_wr_ready", int'(wr_ready), 1);
    chk("sw_rd_en", int'(rd_en), 1);
    wr_valid = 1'b0; rd_ready = 1'b0;

    // Randomized traffic with enable gaps
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      wr_valid = ($urandom_range(0, 99) < 70);
      rd_ready = ($urandom_range(0, 99) < 60);
      enable   = ($urandom_range(0, 99) < 90);
      cyc(1);
    end
    enable = 1'b1;

    // Enable low mid-frame, then reset
    do_reset();
    wr_valid = 1'b1;
    cyc(300);
    rd_ready = 1'b1;
    cyc(10);
    enable = 1'b0;
    #1;
    wa = int'(wr_addr); ra = int'(rd_addr);
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk("en_wr_en", int'(wr_en), 0);
      chk("en_rd_en", int'(rd_en), 0);
      chk("en_wr_ready", int'(wr_ready), 0);
      chk("en_wr_addr_hold", int'(wr_addr), wa);
      chk("en_rd_addr_hold", int'(rd_addr), ra);
      chk("en_out_valid_hold", int'(out_valid), 1);
    end
    enable = 1'b1;
    cyc(2);
    chk("pre_rst_out_valid", int'(out_valid), 1);
    reset = 1'b1;
    #1;
    chk("rst_now_out_valid", int'(out_valid), 0);
    chk("rst_now_overflow", int'(overflow), 0);
    chk("rst_now_wr_bank", int'(wr_bank), 0);
    chk("rst_now_rd_bank", int'(rd_bank), 0);
    chk("rst_now_rd_en", int'(rd_en), 0);
    cyc(1);
    reset = 1'b0;
    #1;
    chk("post_rst_wr_ready", int'(wr_ready), 1);
    chk("post_rst_rd_en", int'(rd_en), 0);
    wr_valid = 1'b0; rd_ready = 1'b0;
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
